// File: rtl/tomasulo_rob.sv
// Eight-entry reorder buffer: allocates tags in issue order, captures CDB results,
// forwards operands by tag and retires strictly in order with mispredict flush.
module tomasulo_rob #(
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3,
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [3:0]        alloc_func,
  input  logic [REG_W-1:0]  alloc_rd,
  output logic              alloc_ready,
  output logic [PTR_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [PTR_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic [PTR_W-1:0]  q_tag1,
  input  logic [PTR_W-1:0]  q_tag2,
  output logic              q_ready1,
  output logic              q_ready2,
  output logic [DATA_W-1:0] q_data1,
  output logic [DATA_W-1:0] q_data2,
  output logic              commit_valid,
  output logic              commit_we,
  output logic [REG_W-1:0]  commit_rd,
  output logic [DATA_W-1:0] commit_data,
  output logic [PTR_W-1:0]  commit_tag,
  output logic              commit_store,
  output logic              flush,
  output logic [PTR_W:0]    count
);

  logic [DEPTH-1:0]  ent_valid;
  logic [DEPTH-1:0]  ent_done;
  logic [3:0]        ent_func  [DEPTH];
  logic [REG_W-1:0]  ent_rd    [DEPTH];
  logic [DATA_W-1:0] ent_value [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;

  logic commit_fire;
  logic mispredict;
  logic alloc_fire;

  always_comb begin
    alloc_ready = (count != (PTR_W+1)'(DEPTH));
    alloc_tag   = tail;
    commit_fire = ent_valid[head] && ent_done[head];
    mispredict  = commit_fire && (ent_func[head][3:1] == 3'b011) && ent_value[head][0];
    // A mispredict retiring this edge squashes the whole buffer, including this alloc.
    alloc_fire  = alloc_valid && alloc_ready && !mispredict;
  end

  always_comb begin
    q_ready1 = 1'b0;
    q_data1  = ent_value[q_tag1];
    if (cdb_valid && (cdb_tag == q_tag1)) begin
      q_ready1 = 1'b1;
      q_data1  = cdb_data;
    end else begin
      q_ready1 = ent_valid[q_tag1] && ent_done[q_tag1];
    end
  end

  always_comb begin
    q_ready2 = 1'b0;
    q_data2  = ent_value[q_tag2];
    if (cdb_valid && (cdb_tag == q_tag2)) begin
      q_ready2 = 1'b1;
      q_data2  = cdb_data;
    end else begin
      q_ready2 = ent_valid[q_tag2] && ent_done[q_tag2];
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      ent_valid    <= '0;
      ent_done     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_func[i]  <= '0;
        ent_rd[i]    <= '0;
        ent_value[i] <= '0;
      end
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_valid <= 1'b0;
      commit_we    <= 1'b0;
      commit_rd    <= '0;
      commit_data  <= '0;
      commit_tag   <= '0;
      commit_store <= 1'b0;
      flush        <= 1'b0;
    end else begin
      commit_valid <= commit_fire;
      commit_we    <= commit_fire && (ent_func[head] <= 4'b0100);
      commit_store <= commit_fire && (ent_func[head] == 4'b0101);
      flush        <= mispredict;
      if (commit_fire) begin
        commit_rd   <= ent_rd[head];
        commit_data <= ent_value[head];
        commit_tag  <= head;
      end

      if (mispredict) begin
        ent_valid <= '0;
        ent_done  <= '0;
        head      <= '0;
        tail      <= '0;
        count     <= '0;
      end else begin
        if (alloc_fire) begin
          ent_valid[tail] <= 1'b1;
          ent_done[tail]  <= 1'b0;
          ent_func[tail]  <= alloc_func;
          ent_rd[tail]    <= alloc_rd;
          tail            <= tail + 1'b1;
        end
        // Commit reads done from before this edge, so a CDB hit on head retires next edge.
        if (cdb_valid && ent_valid[cdb_tag] && !ent_done[cdb_tag]) begin
          ent_value[cdb_tag] <= cdb_data;
          ent_done[cdb_tag]  <= 1'b1;
        end
        if (commit_fire) begin
          ent_valid[head] <= 1'b0;
          ent_done[head]  <= 1'b0;
          head            <= head + 1'b1;
        end
        count <= count + (PTR_W+1)'(alloc_fire) - (PTR_W+1)'(commit_fire);
      end
    end
  end

endmodule

// File: tb/tb_tomasulo_rob.sv
// Self-checking bench for tomasulo_rob: directed scenarios plus random traffic
// compared against a queue-based reorder buffer model.
module tb_tomasulo_rob;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [3:0]  alloc_func;
  logic [3:0]  alloc_rd;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic [2:0]  q_tag1, q_tag2;
  logic        q_ready1, q_ready2;
  logic [15:0] q_data1, q_data2;
  logic        commit_valid, commit_we, commit_store, flush;
  logic [3:0]  commit_rd;
  logic [15:0] commit_data;
  logic [2:0]  commit_tag;
  logic [3:0]  count;

  tomasulo_rob dut (
    .clk1(clk1), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_func(alloc_func), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .q_tag1(q_tag1), .q_tag2(q_tag2), .q_ready1(q_ready1), .q_ready2(q_ready2),
    .q_data1(q_data1), .q_data2(q_data2),
    .commit_valid(commit_valid), .commit_we(commit_we), .commit_rd(commit_rd),
    .commit_data(commit_data), .commit_tag(commit_tag), .commit_store(commit_store),
    .flush(flush), .count(count)
  );

  always #5 clk1 = ~clk1;

  typedef struct {
    logic [3:0]  func;
    logic [3:0]  rd;
    bit          done;
    logic [15:0] value;
  } rob_entry_t;

  // Model: in-flight instructions in program order; tag of rob[i] is (head_tag+i)%8.
  rob_entry_t rob[$];
  int         head_tag;

  int n_checks = 0;
  int n_fail   = 0;

  // Pre-edge (combinational) expectations and observations.
  logic        exp_alloc_ready, obs_alloc_ready;
  logic [2:0]  exp_alloc_tag, obs_alloc_tag;
  logic        exp_qr1, exp_qr2, obs_qr1, obs_qr2;
  logic [15:0] exp_qd1, exp_qd2, obs_qd1, obs_qd2;
  // Post-edge (registered) expectations and observations.
  logic        exp_cv, exp_we, exp_store, exp_flush;
  logic [3:0]  exp_rd;
  logic [15:0] exp_data;
  logic [2:0]  exp_tag;
  logic [3:0]  exp_count;
  logic        obs_cv, obs_we, obs_store, obs_flush;
  logic [3:0]  obs_rd, obs_count;
  logic [15:0] obs_data;
  logic [2:0]  obs_tag;

  function automatic int tag_index(input logic [2:0] t);
    int idx;
    idx = (int'(t) - head_tag + 8) % 8;
    return (idx < rob.size()) ? idx : -1;
  endfunction

  task automatic model_lookup(input logic [2:0] qt, output logic r, output logic [15:0] d);
    int idx;
    r = 1'b0;
    d = 16'h0;
    if (cdb_valid && cdb_tag == qt) begin
      r = 1'b1;
      d = cdb_data;
    end else begin
      idx = tag_index(qt);
      if (idx >= 0 && rob[idx].done) begin
        r = 1'b1;
        d = rob[idx].value;
      end
    end
  endtask

  // Drive one cycle of inputs, sample combinational outputs, advance the model, sample registered outputs.
  task automatic step(input bit av, input logic [3:0] af, input logic [3:0] ard,
                      input bit cv, input logic [2:0] ct, input logic [15:0] cd,
                      input logic [2:0] qt1, input logic [2:0] qt2);
    bit         do_commit, do_flush, accept;
    rob_entry_t e;
    int         idx;
    @(negedge clk1);
    alloc_valid = av; alloc_func = af; alloc_rd = ard;
    cdb_valid = cv; cdb_tag = ct; cdb_data = cd;
    q_tag1 = qt1; q_tag2 = qt2;
    #1;
    obs_alloc_ready = alloc_ready; obs_alloc_tag = alloc_tag;
    obs_qr1 = q_ready1; obs_qr2 = q_ready2; obs_qd1 = q_data1; obs_qd2 = q_data2;
    exp_alloc_ready = (rob.size() < 8);
    exp_alloc_tag   = 3'((head_tag + rob.size()) % 8);
    model_lookup(qt1, exp_qr1, exp_qd1);
    model_lookup(qt2, exp_qr2, exp_qd2);

    accept    = av && (rob.size() < 8);
    do_commit = (rob.size() > 0) && rob[0].done;
    do_flush  = 1'b0;
    exp_cv = do_commit; exp_we = 1'b0; exp_store = 1'b0;
    exp_rd = 4'h0; exp_data = 16'h0; exp_tag = 3'h0;
    if (do_commit) begin
      exp_rd    = rob[0].rd;
      exp_data  = rob[0].value;
      exp_tag   = 3'(head_tag);
      exp_we    = (rob[0].func <= 4'd4);
      exp_store = (rob[0].func == 4'd5);
      do_flush  = (rob[0].func == 4'd6 || rob[0].func == 4'd7) && rob[0].value[0];
    end
    exp_flush = do_flush;
    if (cv) begin
      idx = tag_index(ct);
      if (idx >= 0 && !rob[idx].done) begin
        e = rob[idx]; e.done = 1'b1; e.value = cd; rob[idx] = e;
      end
    end
    if (do_commit) begin
      void'(rob.pop_front());
      head_tag = (head_tag + 1) % 8;
    end
    if (do_flush) begin
      rob.delete();
      head_tag = 0;
    end else if (accept) begin
      e.func = af; e.rd = ard; e.done = 1'b0; e.value = 16'h0;
      rob.push_back(e);
    end
    exp_count = 4'(rob.size());

    @(posedge clk1);
    #1;
    obs_cv = commit_valid; obs_we = commit_we; obs_store = commit_store; obs_flush = flush;
    obs_rd = commit_rd; obs_data = commit_data; obs_tag = commit_tag; obs_count = count;
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 4'h0, 1'b0, 3'h0, 16'h0, 3'h0, 3'h0);
  endtask

  task automatic alloc(input logic [3:0] f, input logic [3:0] r);
    step(1'b1, f, r, 1'b0, 3'h0, 16'h0, 3'h0, 3'h0);
  endtask

  task automatic cdb(input logic [2:0] t, input logic [15:0] d);
    step(1'b0, 4'h0, 4'h0, 1'b1, t, d, 3'h0, 3'h0);
  endtask

  task automatic apply_reset();
    @(negedge clk1);
    rst = 1'b1;
    alloc_valid = 1'b0; alloc_func = 4'h0; alloc_rd = 4'h0;
    cdb_valid = 1'b0; cdb_tag = 3'h0; cdb_data = 16'h0; q_tag1 = 3'h0; q_tag2 = 3'h0;
    rob.delete();
    head_tag = 0;
    @(negedge clk1);
    @(negedge clk1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_checks++;
    if (count !== 4'd0 || commit_valid !== 1'b0 || flush !== 1'b0 || alloc_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_state: count=%0d cv=%b flush=%b ready=%b, required 0 0 0 1",
               count, commit_valid, flush, alloc_ready);
    end
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      idle();
      n_checks++;
      if (obs_count !== 4'd0 || obs_alloc_ready !== 1'b1 || obs_cv !== 1'b0 || obs_flush !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_idle: cycle %0d count=%0d ready=%b cv=%b flush=%b, required 0 1 0 0",
                 i, obs_count, obs_alloc_ready, obs_cv, obs_flush);
      end
    end
  endtask

  task automatic test_in_order();
    apply_reset();
    alloc(4'b0000, 4'd3);
    n_checks++;
    if (obs_alloc_tag !== 3'd0) begin
      n_fail++; $display("[TB] FAIL inorder_tag0: got %0d required 0", obs_alloc_tag);
    end
    alloc(4'b0010, 4'd5);
    n_checks++;
    if (obs_alloc_tag !== 3'd1) begin
      n_fail++; $display("[TB] FAIL inorder_tag1: got %0d required 1", obs_alloc_tag);
    end
    cdb(3'd1, 16'h0014);
    cdb(3'd0, 16'h0007);
    n_checks++;
    if (obs_cv !== 1'b0) begin
      n_fail++; $display("[TB] FAIL inorder_early_commit: commit_valid=%b required 0", obs_cv);
    end
    idle();
    n_checks++;
    if (obs_cv !== 1'b1 || obs_tag !== 3'd0 || obs_rd !== 4'd3 || obs_data !== 16'h0007 || obs_we !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL inorder_commit0: cv=%b tag=%0d rd=%0d data=%h we=%b, required 1 0 3 0007 1",
               obs_cv, obs_tag, obs_rd, obs_data, obs_we);
    end
    idle();
    n_checks++;
    if (obs_cv !== 1'b1 || obs_tag !== 3'd1 || obs_rd !== 4'd5 || obs_data !== 16'h0014 || obs_count !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL inorder_commit1: cv=%b tag=%0d rd=%0d data=%h count=%0d, required 1 1 5 0014 0",
               obs_cv, obs_tag, obs_rd, obs_data, obs_count);
    end
    idle();
    n_checks++;
    if (obs_cv !== 1'b0) begin
      n_fail++; $display("[TB] FAIL inorder_pulse: commit_valid=%b required 0", obs_cv);
    end
  endtask

  task automatic test_full_wrap();
    apply_reset();
    for (int i = 0; i < 8; i++) alloc(4'b0001, 4'(i));
    n_checks++;
    if (obs_count !== 4'd8) begin
      n_fail++; $display("[TB] FAIL full_count: got %0d required 8", obs_count);
    end
    alloc(4'b0001, 4'hF);
    n_checks++;
    if (obs_alloc_ready !== 1'b0 || obs_count !== 4'd8) begin
      n_fail++; $display("[TB] FAIL full_ninth: ready=%b count=%0d, required 0 8", obs_alloc_ready, obs_count);
    end
    step(1'b1, 4'b0001, 4'hE, 1'b1, 3'd0, 16'h1234, 3'h0, 3'h0);
    step(1'b1, 4'b0001, 4'hE, 1'b0, 3'd0, 16'h0, 3'h0, 3'h0);
    n_checks++;
    if (obs_alloc_ready !== 1'b0 || obs_cv !== 1'b1 || obs_count !== 4'd7) begin
      n_fail++;
      $display("[TB] FAIL full_commit_no_alloc: ready=%b cv=%b count=%0d, required 0 1 7",
               obs_alloc_ready, obs_cv, obs_count);
    end
    alloc(4'b0001, 4'hD);
    n_checks++;
    if (obs_alloc_ready !== 1'b1 || obs_alloc_tag !== 3'd0 || obs_count !== 4'd8) begin
      n_fail++;
      $display("[TB] FAIL full_wrap: ready=%b tag=%0d count=%0d, required 1 0 8",
               obs_alloc_ready, obs_alloc_tag, obs_count);
    end
  endtask

  task automatic test_forward();
    apply_reset();
    for (int i = 0; i < 5; i++) alloc(4'b0000, 4'(i));
    step(1'b0, 4'h0, 4'h0, 1'b1, 3'd2, 16'hBEEF, 3'd2, 3'd4);
    n_checks++;
    if (obs_qr1 !== 1'b1 || obs_qd1 !== 16'hBEEF) begin
      n_fail++; $display("[TB] FAIL fwd_cdb: ready1=%b data1=%h, required 1 BEEF", obs_qr1, obs_qd1);
    end
    n_checks++;
    if (obs_qr2 !== 1'b0) begin
      n_fail++; $display("[TB] FAIL fwd_not_done: ready2=%b required 0", obs_qr2);
    end
    step(1'b0, 4'h0, 4'h0, 1'b0, 3'd0, 16'h0, 3'd4, 3'd2);
    n_checks++;
    if (obs_qr2 !== 1'b1 || obs_qd2 !== 16'hBEEF || obs_qr1 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL fwd_stored: ready2=%b data2=%h ready1=%b, required 1 BEEF 0", obs_qr2, obs_qd2, obs_qr1);
    end
  endtask

  task automatic test_store_branch();
    apply_reset();
    alloc(4'b0101, 4'd2);
    alloc(4'b0110, 4'd4);
    cdb(3'd0, 16'h0055);
    cdb(3'd1, 16'h0000);
    n_checks++;
    if (obs_cv !== 1'b1 || obs_store !== 1'b1 || obs_we !== 1'b0) begin
      n_fail++; $display("[TB] FAIL store_commit: cv=%b store=%b we=%b, required 1 1 0", obs_cv, obs_store, obs_we);
    end
    idle();
    n_checks++;
    if (obs_cv !== 1'b1 || obs_we !== 1'b0 || obs_store !== 1'b0 || obs_flush !== 1'b0 || obs_tag !== 3'd1) begin
      n_fail++;
      $display("[TB] FAIL beq_commit: cv=%b we=%b store=%b flush=%b tag=%0d, required 1 0 0 0 1",
               obs_cv, obs_we, obs_store, obs_flush, obs_tag);
    end
  endtask

  task automatic test_mispredict();
    apply_reset();
    alloc(4'b0111, 4'd1);
    alloc(4'b0000, 4'd2);
    alloc(4'b0001, 4'd3);
    cdb(3'd0, 16'h0001);
    step(1'b1, 4'b0000, 4'd9, 1'b1, 3'd1, 16'h0033, 3'h0, 3'h0);
    n_checks++;
    if (obs_flush !== 1'b1 || obs_cv !== 1'b1 || obs_count !== 4'd0 || obs_we !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mispredict_flush: flush=%b cv=%b count=%0d we=%b, required 1 1 0 0",
               obs_flush, obs_cv, obs_count, obs_we);
    end
    cdb(3'd1, 16'h0044);
    n_checks++;
    if (obs_flush !== 1'b0 || obs_cv !== 1'b0 || obs_count !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL mispredict_after: flush=%b cv=%b count=%0d, required 0 0 0", obs_flush, obs_cv, obs_count);
    end
    idle();
    n_checks++;
    if (obs_cv !== 1'b0) begin
      n_fail++; $display("[TB] FAIL mispredict_squashed: commit_valid=%b required 0", obs_cv);
    end
    alloc(4'b0000, 4'd6);
    n_checks++;
    if (obs_alloc_tag !== 3'd0 || obs_count !== 4'd1) begin
      n_fail++; $display("[TB] FAIL mispredict_realloc: tag=%0d count=%0d, required 0 1", obs_alloc_tag, obs_count);
    end
  endtask

  task automatic test_random();
    logic [2:0] t;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      if (rob.size() > 0 && $urandom_range(0, 3) != 0)
        t = 3'((head_tag + $urandom_range(0, rob.size() - 1)) % 8);
      else
        t = 3'($urandom_range(0, 7));
      step(($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)), 4'($urandom),
           ($urandom_range(0, 1) == 1), t, 16'($urandom),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      n_checks++;
      if (obs_alloc_ready !== exp_alloc_ready || obs_alloc_tag !== exp_alloc_tag) begin
        n_fail++;
        $display("[TB] FAIL rnd_alloc: cycle %0d ready=%b tag=%0d, required %b %0d",
                 i, obs_alloc_ready, obs_alloc_tag, exp_alloc_ready, exp_alloc_tag);
      end
      n_checks++;
      if (obs_qr1 !== exp_qr1 || obs_qr2 !== exp_qr2 ||
          (exp_qr1 && obs_qd1 !== exp_qd1) || (exp_qr2 && obs_qd2 !== exp_qd2)) begin
        n_fail++;
        $display("[TB] FAIL rnd_lookup: cycle %0d r1=%b d1=%h r2=%b d2=%h, required %b %h %b %h",
                 i, obs_qr1, obs_qd1, obs_qr2, obs_qd2, exp_qr1, exp_qd1, exp_qr2, exp_qd2);
      end
      n_checks++;
      if (obs_cv !== exp_cv || obs_flush !== exp_flush || obs_we !== exp_we ||
          obs_store !== exp_store || obs_count !== exp_count) begin
        n_fail++;
        $display("[TB] FAIL rnd_commit_ctl: cycle %0d cv=%b flush=%b we=%b store=%b count=%0d, required %b %b %b %b %0d",
                 i, obs_cv, obs_flush, obs_we, obs_store, obs_count, exp_cv, exp_flush, exp_we, exp_store, exp_count);
      end
      if (exp_cv) begin
        n_checks++;
        if (obs_rd !== exp_rd || obs_data !== exp_data || obs_tag !== exp_tag) begin
          n_fail++;
          $display("[TB] FAIL rnd_commit_data: cycle %0d rd=%0d data=%h tag=%0d, required %0d %h %0d",
                   i, obs_rd, obs_data, obs_tag, exp_rd, exp_data, exp_tag);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    alloc_valid = 1'b0; alloc_func = 4'h0; alloc_rd = 4'h0;
    cdb_valid = 1'b0; cdb_tag = 3'h0; cdb_data = 16'h0; q_tag1 = 3'h0; q_tag2 = 3'h0;
    head_tag = 0;
    test_reset();
    test_in_order();
    test_full_wrap();
    test_forward();
    test_store_branch();
    test_mispredict();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
